// File: rtl/quad_steer_gen_if.sv
// Bundle of the control inputs and quadrature/position outputs of quad_steer_gen.
// The controller side (bench or host logic) uses the master modport; the
// generator itself uses the slave modport.
interface quad_steer_gen_if #(
  parameter int NCH  = 2,
  parameter int DIVW = 16,
  parameter int POSW = 8
);
  logic [DIVW-1:0]     clkdiv;
  logic                accel_en;
  logic [NCH-1:0]      left;
  logic [NCH-1:0]      right;
  logic [2*NCH-1:0]    steer;
  logic [NCH*POSW-1:0] pos;
  logic [NCH-1:0]      moving;

  modport master (
    output clkdiv, accel_en, left, right,
    input  steer, pos, moving
  );

  modport slave (
    input  clkdiv, accel_en, left, right,
    output steer, pos, moving
  );
endinterface

// File: rtl/quad_steer_gen.sv
// Multi-channel quadrature step generator. Each channel runs an IDLE/RUN_L/RUN_R
// machine that emits Gray-coded {A,B} steps at a programmable period. The
// position counter tracks the steps, and an optional ramp halves the period
// every ACCEL_STEPS steps, down to clkdiv/8.
module quad_steer_gen #(
  parameter int NCH         = 2,
  parameter int DIVW        = 16,
  parameter int POSW        = 8,
  parameter int ACCEL_STEPS = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  quad_steer_gen_if.slave bus
);

  // Step-in-level counter runs 0..ACCEL_STEPS-1; keep at least one bit.
  localparam int SW = (ACCEL_STEPS < 2) ? 1 : $clog2(ACCEL_STEPS);
  localparam logic [SW-1:0] ACC_LAST = SW'(ACCEL_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_L = 2'd1,
    ST_RUN_R = 2'd2
  } state_t;

  // Gray walk 00->01->11->10 when moving right, the reverse when moving left.
  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic fwd);
    logic [1:0] r;
    case (ph)
      2'b00:   r = fwd ? 2'b01 : 2'b10;
      2'b01:   r = fwd ? 2'b11 : 2'b00;
      2'b11:   r = fwd ? 2'b10 : 2'b01;
      default: r = fwd ? 2'b00 : 2'b11;
    endcase
    return r;
  endfunction

  // Period in CLK cycles; with the ramp active it shrinks by one octave per
  // level but never below one cycle.
  function automatic logic [DIVW-1:0] eff_period(input logic [DIVW-1:0] div,
                                                 input logic [1:0]      lvl,
                                                 input logic            acc);
    logic [DIVW-1:0] sh;
    logic [DIVW-1:0] r;
    sh = div >> lvl;
    if (!acc)          r = div;
    else if (sh == '0) r = DIVW'(1);
    else               r = sh;
    return r;
  endfunction

  logic [1:0]      ph_w  [NCH];
  logic [POSW-1:0] pos_w [NCH];
  logic            mov_w [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t          state_q, state_d;
    logic [DIVW-1:0] div_q, div_base, period;
    logic [SW-1:0]   scnt_q, scnt_base;
    logic [1:0]      lvl_q, lvl_base;
    logic [1:0]      ph_q;
    logic [POSW-1:0] pos_q;
    logic            entering, running, fwd, step;

    // Decode the left/right pair into the target state; both or neither means idle.
    always_comb begin
      state_d = ST_IDLE;
      if (bus.left[g] && !bus.right[g])      state_d = ST_RUN_L;
      else if (bus.right[g] && !bus.left[g]) state_d = ST_RUN_R;
    end

    // A state change restarts the divider and the ramp in the same cycle, so
    // the first step lands exactly one period after the request is seen.
    assign entering  = (state_d != state_q);
    assign running   = (state_d != ST_IDLE);
    assign fwd       = (state_d == ST_RUN_R);
    assign div_base  = entering ? '0 : div_q;
    assign scnt_base = entering ? '0 : scnt_q;
    assign lvl_base  = entering ? 2'd0 : lvl_q;
    assign period    = eff_period(bus.clkdiv, lvl_base, bus.accel_en);
    // >= lets a shortened period fire at once instead of wrapping the divider.
    assign step      = running && (bus.clkdiv != '0) && (div_base >= period - DIVW'(1));

    // Channel state, divider, ramp and registered quadrature/position outputs.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_q <= ST_IDLE;
        div_q   <= '0;
        scnt_q  <= '0;
        lvl_q   <= '0;
        ph_q    <= '0;
        pos_q   <= '0;
      end else begin
        state_q <= state_d;
        div_q   <= div_base;
        scnt_q  <= scnt_base;
        lvl_q   <= lvl_base;
        if (step) begin
          div_q <= '0;
          ph_q  <= phase_step(ph_q, fwd);
          pos_q <= fwd ? pos_q + POSW'(1) : pos_q - POSW'(1);
          if (bus.accel_en) begin
            if (scnt_base == ACC_LAST) begin
              scnt_q <= '0;
              if (lvl_base != 2'd3) lvl_q <= lvl_base + 2'd1;
            end else begin
              scnt_q <= scnt_base + SW'(1);
            end
          end
        end else if (running && (bus.clkdiv != '0)) begin
          div_q <= div_base + DIVW'(1);
        end
        if (!bus.accel_en) begin
          lvl_q  <= '0;
          scnt_q <= '0;
        end
      end
    end

    assign ph_w[g]  = ph_q;
    assign pos_w[g] = pos_q;
    assign mov_w[g] = (state_q != ST_IDLE);
  end

  // Pack the per-channel results onto the output buses.
  always_comb begin
    bus.steer  = '0;
    bus.pos    = '0;
    bus.moving = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.steer[2*i +: 2]     = ph_w[i];
      bus.pos[POSW*i +: POSW] = pos_w[i];
      bus.moving[i]           = mov_w[i];
    end
  end

endmodule

// File: tb/tb_quad_steer_gen.sv
// Bench for quad_steer_gen: a small phase/position model pushes each expected
// channel-0 step (cycle, {A,B}, pos) to a queue as stimulus is applied, and each
// scenario task pops and compares as steps appear on steer.
module tb_quad_steer_gen;
  localparam int NCH = 2, DIVW = 16, POSW = 8, ACCEL_STEPS = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  quad_steer_gen_if #(.NCH(NCH), .DIVW(DIVW), .POSW(POSW)) bus ();

  quad_steer_gen #(.NCH(NCH), .DIVW(DIVW), .POSW(POSW), .ACCEL_STEPS(ACCEL_STEPS)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    int              cyc;
    logic [1:0]      st;
    logic [POSW-1:0] p;
  } exp_t;

  exp_t            sb[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              m_idx[NCH];
  logic [POSW-1:0] m_pos[NCH];

  function automatic logic [1:0] gray(input int i);
    logic [1:0] r;
    case (i & 3)
      0:       r = 2'b00;
      1:       r = 2'b01;
      2:       r = 2'b11;
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_idx[i] = 0;
      m_pos[i] = '0;
    end
  endtask

  // Advance the model by one step and queue the expected channel-0 result.
  task automatic push_step(input int cyc, input int ch, input bit r);
    exp_t e;
    m_idx[ch] = r ? ((m_idx[ch] + 1) & 3) : ((m_idx[ch] + 3) & 3);
    m_pos[ch] = r ? m_pos[ch] + POSW'(1) : m_pos[ch] - POSW'(1);
    if (ch == 0) begin
      e.cyc = cyc;
      e.st  = gray(m_idx[ch]);
      e.p   = m_pos[ch];
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    n_tests += 3;
    if (bus.steer !== '0) begin n_fail++; $display("FAIL reset_steer: got %b want 0", bus.steer); end
    if (bus.pos !== '0) begin n_fail++; $display("FAIL reset_pos: got %h want 0", bus.pos); end
    if (bus.moving !== '0) begin n_fail++; $display("FAIL reset_moving: got %b want 0", bus.moving); end
    RESET = 1'b0;
    tick();
    n_tests++;
    if (bus.steer !== '0 || bus.pos !== '0 || bus.moving !== '0) begin
      n_fail++; $display("FAIL reset_idle: got steer=%b pos=%h moving=%b want all 0", bus.steer, bus.pos, bus.moving);
    end
  endtask

  task automatic test_run_right();
    logic [1:0] prev;
    exp_t e;
    bus.clkdiv = 16'd4; bus.accel_en = 1'b0; bus.right = 2'b01; bus.left = 2'b00;
    for (int k = 1; k <= 4; k++) push_step(4 * k, 0, 1'b1);
    prev = bus.steer[1:0];
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) begin
        n_tests++;
        if (bus.moving[0] !== 1'b1) begin n_fail++; $display("FAIL run_right_moving: got %b want 1", bus.moving[0]); end
      end
      if (bus.steer[1:0] !== prev) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL run_right extra step at cycle %0d: steer=%b", c, bus.steer[1:0]);
        end else begin
          e = sb.pop_front();
          if (c != e.cyc || bus.steer[1:0] !== e.st || bus.pos[POSW-1:0] !== e.p) begin
            n_fail++; $display("FAIL run_right step: got cyc=%0d steer=%b pos=%0d want cyc=%0d steer=%b pos=%0d", c, bus.steer[1:0], bus.pos[POSW-1:0], e.cyc, e.st, e.p);
          end
        end
        prev = bus.steer[1:0];
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL run_right missing steps: got %0d pending want 0", sb.size()); sb.delete(); end
    n_tests++;
    if (bus.pos[POSW-1:0] !== m_pos[0] || bus.moving[0] !== 1'b1) begin
      n_fail++; $display("FAIL run_right_end: got pos=%0d moving=%b want pos=%0d moving=1", bus.pos[POSW-1:0], bus.moving[0], m_pos[0]);
    end
  endtask

  task automatic test_run_left();
    logic [1:0] prev;
    exp_t e;
    bus.right = 2'b00; bus.left = 2'b01;
    push_step(4, 0, 1'b0);
    push_step(8, 0, 1'b0);
    prev = bus.steer[1:0];
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.steer[1:0] !== prev) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL run_left extra step at cycle %0d: steer=%b", c, bus.steer[1:0]);
        end else begin
          e = sb.pop_front();
          if (c != e.cyc || bus.steer[1:0] !== e.st || bus.pos[POSW-1:0] !== e.p) begin
            n_fail++; $display("FAIL run_left step: got cyc=%0d steer=%b pos=%0d want cyc=%0d steer=%b pos=%0d", c, bus.steer[1:0], bus.pos[POSW-1:0], e.cyc, e.st, e.p);
          end
        end
        prev = bus.steer[1:0];
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL run_left missing steps: got %0d pending want 0", sb.size()); sb.delete(); end
    bus.left = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_tests++;
      if (bus.moving[0] !== 1'b0 || bus.steer[1:0] !== gray(m_idx[0]) || bus.pos[POSW-1:0] !== m_pos[0]) begin
        n_fail++; $display("FAIL release_hold: got moving=%b steer=%b pos=%0d want moving=0 steer=%b pos=%0d", bus.moving[0], bus.steer[1:0], bus.pos[POSW-1:0], gray(m_idx[0]), m_pos[0]);
      end
    end
  endtask

  task automatic test_both_requests();
    bus.clkdiv = 16'd2; bus.left = 2'b10; bus.right = 2'b10;
    for (int c = 1; c <= 50; c++) begin
      tick();
      n_tests++;
      if (bus.moving[1] !== 1'b0 || bus.steer[3:2] !== gray(m_idx[1]) || bus.pos[2*POSW-1:POSW] !== m_pos[1]) begin
        n_fail++; $display("FAIL both_requests cyc %0d: got moving=%b steer=%b pos=%0d want moving=0 steer=%b pos=%0d", c, bus.moving[1], bus.steer[3:2], bus.pos[2*POSW-1:POSW], gray(m_idx[1]), m_pos[1]);
      end
    end
    bus.left = 2'b00; bus.right = 2'b00;
    tick();
  endtask

  task automatic test_independent();
    logic [1:0] prev;
    exp_t e;
    bus.clkdiv = 16'd3; bus.left = 2'b01; bus.right = 2'b10;
    push_step(3, 0, 1'b0); push_step(3, 1, 1'b1);
    push_step(6, 0, 1'b0); push_step(6, 1, 1'b1);
    prev = bus.steer[1:0];
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (bus.steer[1:0] !== prev) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL independent extra step at cycle %0d: steer=%b", c, bus.steer[1:0]);
        end else begin
          e = sb.pop_front();
          if (c != e.cyc || bus.steer[1:0] !== e.st || bus.pos[POSW-1:0] !== e.p) begin
            n_fail++; $display("FAIL independent step: got cyc=%0d steer=%b pos=%0d want cyc=%0d steer=%b pos=%0d", c, bus.steer[1:0], bus.pos[POSW-1:0], e.cyc, e.st, e.p);
          end
        end
        prev = bus.steer[1:0];
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL independent missing steps: got %0d pending want 0", sb.size()); sb.delete(); end
    n_tests++;
    if (bus.steer[3:2] !== gray(m_idx[1]) || bus.pos[2*POSW-1:POSW] !== m_pos[1]) begin
      n_fail++; $display("FAIL independent_ch1: got steer=%b pos=%0d want steer=%b pos=%0d", bus.steer[3:2], bus.pos[2*POSW-1:POSW], gray(m_idx[1]), m_pos[1]);
    end
    bus.left = 2'b00; bus.right = 2'b00;
    tick();
  endtask

  task automatic test_clkdiv_zero();
    bus.clkdiv = 16'd0; bus.right = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_tests++;
      if (bus.steer[1:0] !== gray(m_idx[0]) || bus.pos[POSW-1:0] !== m_pos[0]) begin
        n_fail++; $display("FAIL clkdiv_zero cyc %0d: got steer=%b pos=%0d want steer=%b pos=%0d", c, bus.steer[1:0], bus.pos[POSW-1:0], gray(m_idx[0]), m_pos[0]);
      end
    end
    bus.right = 2'b00;
    tick();
  endtask

  task automatic test_period_change();
    logic [1:0] prev;
    exp_t e;
    bus.clkdiv = 16'd8; bus.right = 2'b01;
    push_step(6, 0, 1'b1);
    push_step(10, 0, 1'b1);
    prev = bus.steer[1:0];
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 5) bus.clkdiv = 16'd4;
      if (bus.steer[1:0] !== prev) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL period_change extra step at cycle %0d: steer=%b", c, bus.steer[1:0]);
        end else begin
          e = sb.pop_front();
          if (c != e.cyc || bus.steer[1:0] !== e.st || bus.pos[POSW-1:0] !== e.p) begin
            n_fail++; $display("FAIL period_change step: got cyc=%0d steer=%b pos=%0d want cyc=%0d steer=%b pos=%0d", c, bus.steer[1:0], bus.pos[POSW-1:0], e.cyc, e.st, e.p);
          end
        end
        prev = bus.steer[1:0];
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL period_change missing steps: got %0d pending want 0", sb.size()); sb.delete(); end
    bus.right = 2'b00;
    tick();
  endtask

  task automatic test_accel();
    logic [1:0] prev;
    exp_t e;
    int gaps[10] = '{16, 16, 8, 8, 4, 4, 2, 2, 2, 2};
    int t = 0;
    bus.clkdiv = 16'd16; bus.accel_en = 1'b1; bus.right = 2'b01;
    for (int k = 0; k < 10; k++) begin
      t += gaps[k];
      push_step(t, 0, 1'b1);
    end
    prev = bus.steer[1:0];
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (bus.steer[1:0] !== prev) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL accel extra step at cycle %0d: steer=%b", c, bus.steer[1:0]);
        end else begin
          e = sb.pop_front();
          if (c != e.cyc || bus.steer[1:0] !== e.st || bus.pos[POSW-1:0] !== e.p) begin
            n_fail++; $display("FAIL accel step: got cyc=%0d steer=%b pos=%0d want cyc=%0d steer=%b pos=%0d", c, bus.steer[1:0], bus.pos[POSW-1:0], e.cyc, e.st, e.p);
          end
        end
        prev = bus.steer[1:0];
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL accel missing steps: got %0d pending want 0", sb.size()); sb.delete(); end
    bus.right = 2'b00; bus.accel_en = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    exp_t e;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    model_reset();
    bus.clkdiv = 16'd1; bus.left = 2'b01;
    push_step(1, 0, 1'b0);
    tick();
    bus.left = 2'b00;
    e = sb.pop_front();
    n_tests++;
    if (bus.steer[1:0] !== e.st || bus.pos[POSW-1:0] !== e.p) begin
      n_fail++; $display("FAIL wrap_down: got steer=%b pos=%0d want steer=%b pos=%0d", bus.steer[1:0], bus.pos[POSW-1:0], e.st, e.p);
    end
    bus.right = 2'b01;
    push_step(1, 0, 1'b1);
    tick();
    bus.right = 2'b00;
    e = sb.pop_front();
    n_tests++;
    if (bus.steer[1:0] !== e.st || bus.pos[POSW-1:0] !== e.p) begin
      n_fail++; $display("FAIL wrap_up: got steer=%b pos=%0d want steer=%b pos=%0d", bus.steer[1:0], bus.pos[POSW-1:0], e.st, e.p);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    logic [1:0] prev;
    exp_t e;
    bus.clkdiv = 16'd2; bus.right = 2'b11;
    push_step(2, 0, 1'b1); push_step(2, 1, 1'b1);
    push_step(4, 0, 1'b1); push_step(4, 1, 1'b1);
    prev = bus.steer[1:0];
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (bus.steer[1:0] !== prev) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL pre_reset extra step at cycle %0d: steer=%b", c, bus.steer[1:0]);
        end else begin
          e = sb.pop_front();
          if (c != e.cyc || bus.steer[1:0] !== e.st || bus.pos[POSW-1:0] !== e.p) begin
            n_fail++; $display("FAIL pre_reset step: got cyc=%0d steer=%b pos=%0d want cyc=%0d steer=%b pos=%0d", c, bus.steer[1:0], bus.pos[POSW-1:0], e.cyc, e.st, e.p);
          end
        end
        prev = bus.steer[1:0];
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL pre_reset missing steps: got %0d pending want 0", sb.size()); sb.delete(); end
    bus.clkdiv = 16'd8;
    tick(); tick(); tick();
    RESET = 1'b1;
    tick();
    n_tests++;
    if (bus.steer !== '0 || bus.pos !== '0 || bus.moving !== '0) begin
      n_fail++; $display("FAIL midrun_reset: got steer=%b pos=%h moving=%b want all 0", bus.steer, bus.pos, bus.moving);
    end
    RESET = 1'b0;
    model_reset();
    bus.right = 2'b01;
    push_step(8, 0, 1'b1);
    prev = bus.steer[1:0];
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.steer[1:0] !== prev) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL post_reset extra step at cycle %0d: steer=%b", c, bus.steer[1:0]);
        end else begin
          e = sb.pop_front();
          if (c != e.cyc || bus.steer[1:0] !== e.st || bus.pos[POSW-1:0] !== e.p) begin
            n_fail++; $display("FAIL post_reset step: got cyc=%0d steer=%b pos=%0d want cyc=%0d steer=%b pos=%0d", c, bus.steer[1:0], bus.pos[POSW-1:0], e.cyc, e.st, e.p);
          end
        end
        prev = bus.steer[1:0];
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL post_reset missing steps: got %0d pending want 0", sb.size()); sb.delete(); end
    bus.right = 2'b00;
    tick();
  endtask

  initial begin
    bus.clkdiv   = '0;
    bus.accel_en = 1'b0;
    bus.left     = '0;
    bus.right    = '0;
    model_reset();
    test_reset();
    test_run_right();
    test_run_left();
    test_both_requests();
    test_independent();
    test_clkdiv_zero();
    test_period_change();
    test_accel();
    test_wrap();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
